write_controller: RTL and testbench
===================================

Name: write_controller

Overview:
- Register-write front end. It consumes the UART_PACKET receive stream, decodes write packets (address byte + 4 data bytes, MSB first) and assembles a 32-bit word.
- It then issues a single-cycle write strobe to the register file.
- It returns a 1-byte acknowledge packet on the transmit stream, honouring ready back-pressure.
- It is the write-side counterpart of the register read path; both share the same packet interface and the same register file.

Parameters:
- WR_DEST, 8'h01, Destination value that selects this block.
- DATA_LENGTH, 4, number of data bytes per write (word = 8*DATA_LENGTH bits; only 4 is supported).
- ACK_CODE, 8'hA5, Data byte carried by the acknowledge packet.

Ports:
- ipClk  input  1  system clock, all logic on rising edge
- ipReset  input  1  synchronous reset, active-low (0 = reset)
- ipRxStream  input  UART_PACKET  receive stream (Source, Destination, Length, SoP, EoP, Data[7:0], Valid)
- ipTxReady  input  1  downstream transmitter can accept a byte
- opTxStream  output  UART_PACKET  acknowledge stream
- opWrAddress  output  8  register write address
- opWrData  output  32  register write data
- opWrEnable  output  1  write strobe, one cycle per accepted packet

Behaviour:
- Reset is sampled only on ipClk edges. ipReset==0 forces:
  - state IDLE, byte counter 0, opWrEnable 0, opWrAddress 0, opWrData 0;
  - every opTxStream field 0.
- Reset overrides all other activity, including mid-packet and mid-acknowledge. A partial packet is lost and no write occurs.
- An Rx byte counts only on a cycle where ipRxStream.Valid==1. Valid gaps between bytes are legal; state holds during gaps.
- States:
  - IDLE: on a valid byte with SoP=1, Destination==WR_DEST and Length==DATA_LENGTH+1, latch Data as the address, latch Source, clear the counter, go to GET_DATA. A valid SoP byte that fails either check goes to DISCARD, unless it also has EoP=1, in which case stay in IDLE. Non-SoP bytes are ignored.
  - GET_DATA: each valid byte shifts into the data register MSB first (byte 1 -> [31:24] ... byte 4 -> [7:0]) and increments the counter.
    - 4th byte with EoP=1 -> WRITE.
    - 4th byte with EoP=0 -> DISCARD.
    - EoP=1 on bytes 1-3 -> IDLE, no write.
    - SoP=1 on any byte here restarts decoding as if in IDLE; the old packet is dropped.
  - WRITE: opWrEnable=1 for exactly this one cycle, with opWrAddress/opWrData stable from this cycle until the next write. Next state ACK.
  - ACK: drive opTxStream with:
    - Valid=1, SoP=1, EoP=1, Length=1;
    - Source=WR_DEST, Destination=latched Rx Source, Data=ACK_CODE.
    The byte transfers on the first edge with Valid && ipTxReady. On that edge, clear Valid and go to IDLE. Fields stay stable while waiting. Rx bytes arriving in ACK are discarded; if any arrive, exit to DISCARD instead of IDLE unless the discarded byte had EoP=1.
  - DISCARD: ignore bytes until a valid byte with EoP=1, then IDLE. A valid SoP byte here is handled as in IDLE.
- Latency:
  - opWrEnable rises 1 cycle after the edge that accepts the final data byte.
  - opTxStream.Valid rises 1 cycle after that.
  - Minimum packet-to-packet spacing is final byte + 2 cycles + Tx stall time.
- opTxStream.Valid is 0 in every state except ACK.
- Only one write per packet; no write ever occurs for a malformed packet.

Test Plan:
- Normal write: Rx SoP addr 0x10, then 0xDE, 0xAD, 0xBE, 0xEF (EoP on last), Dest 0x01, Len 5, Source 0x07, ipTxReady=1 -> one-cycle opWrEnable with addr 0x10, data 0xDEADBEEF; next cycle Tx byte 0xA5, Dest 0x07, Source 0x01, SoP=EoP=1.
- Filtering: same packet with Dest 0x00, then with Len 3 -> opWrEnable never asserts, no Tx Valid; a following good packet to addr 0x22 writes correctly.
- Malformed: EoP on the 2nd data byte -> no write, back to IDLE; 4th data byte without EoP, then 2 junk bytes with EoP on the last -> no write, next good packet accepted.
- Back-pressure and gaps: Rx Valid low for 3 cycles between every byte; ipTxReady low for 5 cycles during ACK -> data 0x01234567 still written once; Tx Valid held 6 cycles with fields constant; exactly one transfer.
- Reset mid-operation: ipReset=0 after the 2nd data byte, then after entering ACK -> all outputs 0 the next cycle, no write, no Tx transfer; a following good packet works.
- SoP restart: a new SoP packet (addr 0x30, data 0x11223344) arrives after 2 bytes of a previous packet -> single write of 0x11223344 to 0x30.

Source files
------------

// File: rtl/write_controller.sv
// write_controller: register-write front end for the UART packet link.
// Decodes write packets, strobes the register file, returns a 1-byte ack.

package uart_pkg;
    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
        logic       Valid;
    } UART_PACKET;
endpackage

module write_controller
    import uart_pkg::*;
#(
    parameter logic [7:0] WR_DEST     = 8'h01,
    parameter int         DATA_LENGTH = 4,
    parameter logic [7:0] ACK_CODE    = 8'hA5
) (
    input  logic                     ipClk,
    input  logic                     ipReset,
    input  UART_PACKET               ipRxStream,
    input  logic                     ipTxReady,
    output UART_PACKET               opTxStream,
    output logic [7:0]               opWrAddress,
    output logic [8*DATA_LENGTH-1:0] opWrData,
    output logic                     opWrEnable
);
    localparam int         WORD_W   = 8 * DATA_LENGTH;
    localparam logic [7:0] PKT_LEN  = 8'(DATA_LENGTH + 1);
    localparam logic [2:0] LAST_IDX = 3'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        WRITE,
        ACK,
        DISCARD
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        src_q, src_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              pend_q, pend_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    UART_PACKET        tx_q, tx_d;

    logic              rx_v;
    logic              rx_sop;
    logic              rx_eop;
    logic              hdr_ok;
    logic              restart;
    logic              tx_fire;
    logic              pend_now;
    logic [WORD_W-1:0] data_shift;
    UART_PACKET        ack_pkt;

    // Per-byte decode of the Rx stream and the ack packet image
    always_comb begin
        rx_v       = ipRxStream.Valid;
        rx_sop     = rx_v && ipRxStream.SoP;
        rx_eop     = rx_v && ipRxStream.EoP;
        hdr_ok     = (ipRxStream.Destination == WR_DEST)
                  && (ipRxStream.Length == PKT_LEN);
        data_shift = {data_q[WORD_W-9:0], ipRxStream.Data};
        tx_fire    = tx_q.Valid && ipTxReady;
        // A byte swallowed during the ack leaves us mid-packet
        // unless it closed that packet.
        pend_now   = rx_v ? !ipRxStream.EoP : pend_q;
        restart    = rx_sop && (state_q == IDLE
                             || state_q == GET_DATA
                             || state_q == DISCARD);
        ack_pkt             = '0;
        ack_pkt.Source      = WR_DEST;
        ack_pkt.Destination = src_q;
        ack_pkt.Length      = 8'd1;
        ack_pkt.SoP         = 1'b1;
        ack_pkt.EoP         = 1'b1;
        ack_pkt.Data        = ACK_CODE;
        ack_pkt.Valid       = 1'b1;
    end

    // Next-state and next-output computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        src_d     = src_q;
        data_d    = data_q;
        pend_d    = pend_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        tx_d      = tx_q;

        unique case (state_q)
            IDLE: begin
            end
            GET_DATA: begin
                if (rx_v && !ipRxStream.SoP) begin
                    data_d = data_shift;
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == LAST_IDX) begin
                        if (ipRxStream.EoP) begin
                            state_d   = WRITE;
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = data_shift;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else if (ipRxStream.EoP) begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                state_d = ACK;
                tx_d    = ack_pkt;
                pend_d  = rx_v && !ipRxStream.EoP;
            end
            ACK: begin
                pend_d = pend_now;
                if (tx_fire) begin
                    tx_d    = '0;
                    pend_d  = 1'b0;
                    state_d = pend_now ? DISCARD : IDLE;
                end
            end
            DISCARD: begin
                if (rx_eop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any SoP outside the write/ack phase starts a fresh decode
        if (restart) begin
            cnt_d  = '0;
            data_d = '0;
            if (hdr_ok) begin
                state_d = GET_DATA;
                addr_d  = ipRxStream.Data;
                src_d   = ipRxStream.Source;
            end else begin
                state_d = ipRxStream.EoP ? IDLE : DISCARD;
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            src_q     <= '0;
            data_q    <= '0;
            pend_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            tx_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            src_q     <= src_d;
            data_q    <= data_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            tx_q      <= tx_d;
        end
    end

    assign opTxStream  = tx_q;
    assign opWrAddress = wr_addr_q;
    assign opWrData    = wr_data_q;
    assign opWrEnable  = wr_en_q;

endmodule

// File: tb/tb_write_controller.sv
// tb_write_controller: vector table, multi-cycle corner sequences and
// random packets checked against a packet-level reference model.

module tb_write_controller;
    import uart_pkg::*;

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [7:0]  len;
        logic [7:0]  adr;
        logic [31:0] word;
        int          ndata;
        int          eop_at;
        int          exp_we;
        logic [7:0]  exp_adr;
        logic [31:0] exp_dat;
    } vec_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    UART_PACKET  rx       = '0;
    logic        tx_ready = 1'b1;
    UART_PACKET  tx;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        we;

    int          n_vec   = 0;
    int          n_bad   = 0;
    int          wr_cnt  = 0;
    int          tx_cnt  = 0;
    logic [7:0]  last_wa = '0;
    logic [31:0] last_wd = '0;
    logic        prev_we = 1'b0;
    logic [7:0]  exp_ack_dst = '0;
    bit          rnd_ready   = 1'b0;
    logic [7:0]  hsrc = '0;
    logic [7:0]  hdst = '0;
    logic [7:0]  hlen = '0;
    logic [7:0]  pq_d[$];
    bit          pq_e[$];
    vec_t        tbl[8];

    write_controller #(
        .WR_DEST    (8'h01),
        .DATA_LENGTH(4),
        .ACK_CODE   (8'hA5)
    ) dut (
        .ipClk      (clk),
        .ipReset    (rst_n),
        .ipRxStream (rx),
        .ipTxReady  (tx_ready),
        .opTxStream (tx),
        .opWrAddress(wa),
        .opWrData   (wd),
        .opWrEnable (we)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic UART_PACKET ack_of(input logic [7:0] dst);
        UART_PACKET p;
        p             = '0;
        p.Source      = 8'h01;
        p.Destination = dst;
        p.Length      = 8'd1;
        p.SoP         = 1'b1;
        p.EoP         = 1'b1;
        p.Data        = 8'hA5;
        p.Valid       = 1'b1;
        return p;
    endfunction

    // Monitor: counts write strobes and acknowledge transfers
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_cnt++;
            last_wa = wa;
            last_wd = wd;
            check("we_one_cycle", 64'(prev_we), 64'd0);
        end
        prev_we = (we === 1'b1);
        if (rst_n && tx.Valid === 1'b1 && tx_ready) begin
            tx_cnt++;
            check("ack_fields", 64'(tx), 64'(ack_of(exp_ack_dst)));
        end
    end

    // Random Tx back-pressure while enabled
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input logic s,
                       input logic e, input int gap);
        rx.Valid = 1'b0;
        repeat (gap) cyc();
        rx.Source      = hsrc;
        rx.Destination = hdst;
        rx.Length      = hlen;
        rx.SoP         = s;
        rx.EoP         = e;
        rx.Data        = b;
        rx.Valid       = 1'b1;
        cyc();
        rx.Valid = 1'b0;
    endtask

    task automatic fill(input logic [31:0] w, input int n, input int ea);
        pq_d.delete();
        pq_e.delete();
        for (int i = 0; i < n; i++) begin
            pq_d.push_back(i < 4 ? w[31-8*i -: 8] : 8'h55);
            pq_e.push_back(i == ea);
        end
    endtask

    task automatic send_pkt(input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input logic [7:0] a,
                            input bit heop, input int gmin, input int gmax);
        hsrc = s;
        hdst = d;
        hlen = l;
        put(a, 1'b1, heop, int'($urandom_range(gmax, gmin)));
        foreach (pq_d[i])
            put(pq_d[i], 1'b0, pq_e[i], int'($urandom_range(gmax, gmin)));
    endtask

    task automatic pkt_check(input string nm, input int exp_w,
                             input logic [7:0] ea, input logic [31:0] ed,
                             input int w0, input int t0);
        if (exp_w != 0)
            for (int i = 0; i < 80 && tx_cnt == t0; i++) cyc();
        repeat (6) cyc();
        check({nm, "_writes"}, 64'(wr_cnt - w0), 64'(exp_w));
        check({nm, "_acks"}, 64'(tx_cnt - t0), 64'(exp_w));
        if (exp_w != 0) begin
            check({nm, "_adr"}, 64'(last_wa), 64'(ea));
            check({nm, "_dat"}, 64'(last_wd), 64'(ed));
        end
    endtask

    initial begin
        int w0;
        int t0;
        UART_PACKET snap;

        tbl[0] = '{8'h07, 8'h01, 8'd5, 8'h10, 32'hDEADBEEF, 4, 3,
                   1, 8'h10, 32'hDEADBEEF};
        tbl[1] = '{8'h07, 8'h00, 8'd5, 8'h10, 32'hDEADBEEF, 4, 3,
                   0, 8'h00, 32'h0};
        tbl[2] = '{8'h07, 8'h01, 8'd3, 8'h10, 32'hDEADBEEF, 4, 3,
                   0, 8'h00, 32'h0};
        tbl[3] = '{8'h3C, 8'h01, 8'd5, 8'h22, 32'hCAFEF00D, 4, 3,
                   1, 8'h22, 32'hCAFEF00D};
        tbl[4] = '{8'h07, 8'h01, 8'd5, 8'h11, 32'h12345678, 2, 1,
                   0, 8'h00, 32'h0};
        tbl[5] = '{8'h07, 8'h01, 8'd5, 8'h12, 32'h87654321, 6, 5,
                   0, 8'h00, 32'h0};
        tbl[6] = '{8'h99, 8'h01, 8'd5, 8'h5A, 32'h0BADF00D, 4, 3,
                   1, 8'h5A, 32'h0BADF00D};
        tbl[7] = '{8'h07, 8'h02, 8'd5, 8'h13, 32'h0, 0, -1,
                   0, 8'h00, 32'h0};

        // reset state
        repeat (3) cyc();
        check("rst_we", 64'(we), 64'd0);
        check("rst_adr", 64'(wa), 64'd0);
        check("rst_dat", 64'(wd), 64'd0);
        check("rst_tx", 64'(tx), 64'd0);
        rst_n = 1'b1;
        cyc();

        // normal write with cycle-exact latency
        fill(32'hDEADBEEF, 4, 3);
        exp_ack_dst = 8'h07;
        w0 = wr_cnt;
        t0 = tx_cnt;
        send_pkt(8'h07, 8'h01, 8'd5, 8'h10, 1'b0, 0, 0);
        check("lat_we", 64'(we), 64'd1);
        check("lat_adr", 64'(wa), 64'h10);
        check("lat_dat", 64'(wd), 64'hDEADBEEF);
        check("lat_txv_early", 64'(tx.Valid), 64'd0);
        cyc();
        check("lat_we_drop", 64'(we), 64'd0);
        check("lat_tx", 64'(tx), 64'(ack_of(8'h07)));
        cyc();
        check("lat_txv_clr", 64'(tx.Valid), 64'd0);
        pkt_check("lat", 1, 8'h10, 32'hDEADBEEF, w0, t0);

        // vector table
        foreach (tbl[i]) begin
            fill(tbl[i].word, tbl[i].ndata, tbl[i].eop_at);
            exp_ack_dst = tbl[i].src;
            w0 = wr_cnt;
            t0 = tx_cnt;
            send_pkt(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].adr,
                     tbl[i].eop_at < 0, 0, 0);
            pkt_check($sformatf("vec%0d", i), tbl[i].exp_we,
                      tbl[i].exp_adr, tbl[i].exp_dat, w0, t0);
        end

        // Rx gaps of 3 and a 5-cycle Tx stall
        tx_ready = 1'b0;
        fill(32'h01234567, 4, 3);
        exp_ack_dst = 8'h12;
        w0 = wr_cnt;
        t0 = tx_cnt;
        send_pkt(8'h12, 8'h01, 8'd5, 8'h44, 1'b0, 3, 3);
        check("bp_we", 64'(we), 64'd1);
        cyc();
        snap = tx;
        check("bp_txv", 64'(tx.Valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("bp_hold%0d", i), 64'(tx), 64'(snap));
        end
        tx_ready = 1'b1;
        cyc();
        check("bp_txv_clr", 64'(tx.Valid), 64'd0);
        pkt_check("bp", 1, 8'h44, 32'h01234567, w0, t0);

        // reset after the 2nd data byte
        w0 = wr_cnt;
        t0 = tx_cnt;
        hsrc = 8'h07;
        hdst = 8'h01;
        hlen = 8'd5;
        put(8'h66, 1'b1, 1'b0, 0);
        put(8'hDE, 1'b0, 1'b0, 0);
        put(8'hAD, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        cyc();
        check("rstd_we", 64'(we), 64'd0);
        check("rstd_adr", 64'(wa), 64'd0);
        check("rstd_dat", 64'(wd), 64'd0);
        check("rstd_tx", 64'(tx), 64'd0);
        rst_n = 1'b1;
        put(8'hBE, 1'b0, 1'b0, 0);
        put(8'hEF, 1'b0, 1'b1, 0);
        pkt_check("rstd", 0, 8'h00, 32'h0, w0, t0);

        // reset while the ack is waiting
        tx_ready = 1'b0;
        fill(32'hA1B2C3D4, 4, 3);
        exp_ack_dst = 8'h21;
        w0 = wr_cnt;
        t0 = tx_cnt;
        send_pkt(8'h21, 8'h01, 8'd5, 8'h77, 1'b0, 0, 0);
        cyc();
        check("rsta_txv", 64'(tx.Valid), 64'd1);
        rst_n = 1'b0;
        cyc();
        check("rsta_we", 64'(we), 64'd0);
        check("rsta_adr", 64'(wa), 64'd0);
        check("rsta_dat", 64'(wd), 64'd0);
        check("rsta_tx", 64'(tx), 64'd0);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        repeat (5) cyc();
        check("rsta_writes", 64'(wr_cnt - w0), 64'd1);
        check("rsta_acks", 64'(tx_cnt - t0), 64'd0);

        // good packet after the resets
        fill(32'hFEEDC0DE, 4, 3);
        exp_ack_dst = 8'h07;
        w0 = wr_cnt;
        t0 = tx_cnt;
        send_pkt(8'h07, 8'h01, 8'd5, 8'h22, 1'b0, 0, 1);
        pkt_check("post_rst", 1, 8'h22, 32'hFEEDC0DE, w0, t0);

        // SoP restart in the middle of a packet
        w0 = wr_cnt;
        t0 = tx_cnt;
        hsrc = 8'h0A;
        hdst = 8'h01;
        hlen = 8'd5;
        put(8'h70, 1'b1, 1'b0, 0);
        put(8'h99, 1'b0, 1'b0, 0);
        put(8'h88, 1'b0, 1'b0, 0);
        fill(32'h11223344, 4, 3);
        exp_ack_dst = 8'h0B;
        send_pkt(8'h0B, 8'h01, 8'd5, 8'h30, 1'b0, 0, 0);
        pkt_check("restart", 1, 8'h30, 32'h11223344, w0, t0);

        // random packets against the packet-level model
        rnd_ready = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int          kind;
            int          n;
            int          feop;
            logic [7:0]  s;
            logic [7:0]  d;
            logic [7:0]  l;
            logic [7:0]  a;
            logic [31:0] ew;
            bit          hok;
            int          exp_w;
            kind = int'($urandom_range(0, 4));
            s    = 8'($urandom);
            a    = 8'($urandom);
            d    = 8'h01;
            l    = 8'd5;
            n    = 4;
            if (kind == 1) d = 8'($urandom_range(2, 255));
            if (kind == 2) l = 8'($urandom_range(6, 12));
            if (kind == 1 || kind == 2) n = int'($urandom_range(0, 5));
            if (kind == 3) n = int'($urandom_range(1, 3));
            if (kind == 4) n = int'($urandom_range(5, 7));
            pq_d.delete();
            pq_e.delete();
            for (int i = 0; i < n; i++) begin
                pq_d.push_back(8'($urandom));
                pq_e.push_back(i == n - 1);
            end
            hok  = (d == 8'h01) && (l == 8'd5);
            feop = -1;
            foreach (pq_e[i])
                if (pq_e[i] && feop < 0) feop = i;
            exp_w = (hok && feop == 3) ? 1 : 0;
            ew = '0;
            for (int i = 0; i < 4 && i < n; i++) ew = {ew[23:0], pq_d[i]};
            exp_ack_dst = s;
            w0 = wr_cnt;
            t0 = tx_cnt;
            send_pkt(s, d, l, a, n == 0, 0, 2);
            pkt_check($sformatf("rnd%0d", p), exp_w, a, ew, w0, t0);
        end
        rnd_ready = 1'b0;
        tx_ready  = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
